// File: rtl/access_control_param.sv
// Parking access controller: arrival detection, PIN check with attempt limit,
// gate-open timeout, tailgating detection and PIN-only lockout recovery.
module access_control_param #(
  parameter int                     ANCHO_CLAVE    = 8,
  parameter logic [ANCHO_CLAVE-1:0] CLAVE_CORRECTA = 8'h5A,
  parameter int                     MAX_INTENTOS   = 3,
  parameter int                     ANCHO_INTENTOS = 2,
  parameter int                     TIEMPO_LIMITE  = 200,
  parameter int                     ANCHO_TIEMPO   = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_sensor_llegada_vehiculo,
  input  logic                      i_sensor_ingreso_vehiculo,
  input  logic [ANCHO_CLAVE-1:0]    i_clave_ingresada,
  input  logic                      i_clave_valida,
  output logic                      o_senal_compuerta,
  output logic                      o_senal_alarma_pin,
  output logic                      o_senal_alarma_bloqueo,
  output logic [ANCHO_INTENTOS-1:0] o_intentos_fallidos,
  output logic [3:0]                o_estado
);

  localparam logic [ANCHO_INTENTOS-1:0] MAX_I = ANCHO_INTENTOS'(MAX_INTENTOS);
  localparam logic [ANCHO_TIEMPO-1:0]   T_FIN = ANCHO_TIEMPO'(TIEMPO_LIMITE - 1);

  typedef enum logic [3:0] {
    ESPERA     = 4'b0001,
    VEHICULO   = 4'b0010,
    INGRESANDO = 4'b0100,
    BLOQUEO    = 4'b1000
  } estado_t;

  estado_t                   r_estado, w_estado;
  logic [ANCHO_INTENTOS-1:0] r_intentos, w_intentos;
  logic [ANCHO_TIEMPO-1:0]   r_timer, w_timer;
  logic                      r_vio, w_vio;
  logic                      r_pin, w_pin;

  logic                      w_clave_ok;
  logic [ANCHO_INTENTOS-1:0] w_intentos_inc;

  assign w_clave_ok     = (i_clave_ingresada == CLAVE_CORRECTA);
  // Only used in VEHICULO, where r_intentos < MAX_I always holds, so no wrap.
  assign w_intentos_inc = r_intentos + 1'b1;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_estado   <= ESPERA;
      r_intentos <= '0;
      r_timer    <= '0;
      r_vio      <= 1'b0;
      r_pin      <= 1'b0;
    end else begin
      r_estado   <= w_estado;
      r_intentos <= w_intentos;
      r_timer    <= w_timer;
      r_vio      <= w_vio;
      r_pin      <= w_pin;
    end
  end

  always_comb begin
    w_estado   = r_estado;
    w_intentos = r_intentos;
    w_timer    = r_timer;
    w_vio      = r_vio;
    w_pin      = r_pin;
    case (r_estado)
      ESPERA: begin
        if (i_sensor_ingreso_vehiculo)      w_estado = BLOQUEO;
        else if (i_sensor_llegada_vehiculo) w_estado = VEHICULO;
      end
      VEHICULO: begin
        if (i_sensor_ingreso_vehiculo) begin
          w_estado = BLOQUEO;
        end else if (i_clave_valida && w_clave_ok) begin
          w_estado   = INGRESANDO;
          w_intentos = '0;
          w_pin      = 1'b0;
          w_timer    = '0;
          w_vio      = 1'b0;
        end else if (i_clave_valida) begin
          w_pin      = 1'b1;
          w_intentos = w_intentos_inc;
          if (w_intentos_inc == MAX_I) w_estado = BLOQUEO;
        end else if (!i_sensor_llegada_vehiculo) begin
          w_estado   = ESPERA;
          w_intentos = '0;
          w_pin      = 1'b0;
        end
      end
      INGRESANDO: begin
        if (i_sensor_llegada_vehiculo && i_sensor_ingreso_vehiculo) begin
          w_estado = BLOQUEO;
        end else if (r_vio && !i_sensor_ingreso_vehiculo) begin
          w_estado = ESPERA;
        end else begin
          if (i_sensor_ingreso_vehiculo) w_vio = 1'b1;
          // Timeout only runs until the vehicle is seen entering.
          if (!r_vio) begin
            if (r_timer == T_FIN) begin
              if (!i_sensor_ingreso_vehiculo) w_estado = ESPERA;
            end else begin
              w_timer = r_timer + 1'b1;
            end
          end
        end
      end
      BLOQUEO: begin
        if (i_clave_valida && w_clave_ok) begin
          w_estado   = ESPERA;
          w_intentos = '0;
          w_pin      = 1'b0;
        end else if (i_clave_valida) begin
          w_pin = 1'b1;
        end
      end
      default: w_estado = ESPERA;
    endcase
  end

  assign o_estado               = r_estado;
  assign o_senal_compuerta      = (r_estado == INGRESANDO);
  assign o_senal_alarma_bloqueo = (r_estado == BLOQUEO);
  assign o_senal_alarma_pin     = r_pin;
  assign o_intentos_fallidos    = r_intentos;

endmodule

// File: tb/tb_access_control_param.sv
// Scoreboard bench for access_control_param: default build plus a 16-bit PIN,
// five-attempt build sharing the clock and reset.
module tb_access_control_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       lleg1 = 0, ingr1 = 0, val1 = 0;
  logic [7:0] clave1 = '0;
  logic       comp1, pin1, blq1;
  logic [1:0] int1;
  logic [3:0] est1;

  logic        lleg2 = 0, ingr2 = 0, val2 = 0;
  logic [15:0] clave2 = '0;
  logic        comp2, pin2, blq2;
  logic [2:0]  int2;
  logic [3:0]  est2;

  access_control_param dut1 (
    .i_clock(clk), .i_reset(rst),
    .i_sensor_llegada_vehiculo(lleg1), .i_sensor_ingreso_vehiculo(ingr1),
    .i_clave_ingresada(clave1), .i_clave_valida(val1),
    .o_senal_compuerta(comp1), .o_senal_alarma_pin(pin1),
    .o_senal_alarma_bloqueo(blq1), .o_intentos_fallidos(int1), .o_estado(est1)
  );

  access_control_param #(
    .ANCHO_CLAVE(16), .CLAVE_CORRECTA(16'hA5C3), .MAX_INTENTOS(5),
    .ANCHO_INTENTOS(3), .TIEMPO_LIMITE(200), .ANCHO_TIEMPO(8)
  ) dut2 (
    .i_clock(clk), .i_reset(rst),
    .i_sensor_llegada_vehiculo(lleg2), .i_sensor_ingreso_vehiculo(ingr2),
    .i_clave_ingresada(clave2), .i_clave_valida(val2),
    .o_senal_compuerta(comp2), .o_senal_alarma_pin(pin2),
    .o_senal_alarma_bloqueo(blq2), .o_intentos_fallidos(int2), .o_estado(est2)
  );

  localparam logic [3:0] E = 4'b0001, V = 4'b0010, I = 4'b0100, B = 4'b1000;

  typedef struct {
    string      tag;
    int         d;
    logic [9:0] obs;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Observation word: {estado, compuerta, alarma_pin, alarma_bloqueo, intentos[2:0]}
  function automatic logic [9:0] observed(input int d);
    if (d == 1) return {est1, comp1, pin1, blq1, 1'b0, int1};
    else        return {est2, comp2, pin2, blq2, int2};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int d, input logic lleg, input logic ingr, input logic val,
                      input logic [15:0] clave, input logic [3:0] est, input logic pin,
                      input logic [2:0] nint, input string tag);
    exp_t e;
    if (d == 1) begin
      lleg1 = lleg; ingr1 = ingr; val1 = val; clave1 = clave[7:0];
    end else begin
      lleg2 = lleg; ingr2 = ingr; val2 = val; clave2 = clave;
    end
    e.tag = tag;
    e.d   = d;
    e.obs = {est, est == I, pin, est == B, nint};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq(e.tag, 32'(observed(e.d)), 32'(e.obs));
    $display("step %-14s dut%0d obs=%b exp=%b", e.tag, e.d, observed(e.d), e.obs);
    lleg1 = 0; ingr1 = 0; val1 = 0; clave1 = '0;
    lleg2 = 0; ingr2 = 0; val2 = 0; clave2 = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("rst_dut1", 32'(observed(1)), 32'({E, 6'b0}));
    check_eq("rst_dut2", 32'(observed(2)), 32'({E, 6'b0}));
    @(posedge clk); #1; rst = 1'b0;

    // 1: normal entry
    step(1, 0, 0, 1, 16'h5A, E, 0, 0, "esp_ign_pin");
    step(1, 1, 0, 0, 16'h00, V, 0, 0, "arrive");
    step(1, 1, 0, 1, 16'h5A, I, 0, 0, "pin_ok");
    for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 16'h00, I, 0, 0, "passing");
    step(1, 0, 0, 0, 16'h00, E, 0, 0, "passed");

    // 2: three wrong PINs -> lockout, correct PIN recovers
    step(1, 1, 0, 0, 16'h00, V, 0, 0, "arrive2");
    step(1, 1, 0, 1, 16'h00, V, 1, 1, "wrong1");
    step(1, 1, 0, 1, 16'h11, V, 1, 2, "wrong2");
    step(1, 1, 0, 1, 16'h22, B, 1, 3, "wrong3_lock");
    step(1, 1, 1, 0, 16'h00, B, 1, 3, "lock_ign_sens");
    step(1, 1, 0, 1, 16'h5A, E, 0, 0, "lock_release");

    // 3: gate timeout after exactly 200 edges
    step(1, 1, 0, 0, 16'h00, V, 0, 0, "arrive3");
    step(1, 1, 0, 1, 16'h5A, I, 0, 0, "pin_ok3");
    for (int k = 1; k < 200; k++) step(1, 0, 0, 0, 16'h00, I, 0, 0, "open_wait");
    step(1, 0, 0, 0, 16'h00, E, 0, 0, "timeout");

    // 4: tailgating, wrong PINs in lockout keep intentos at 0
    step(1, 1, 0, 0, 16'h00, V, 0, 0, "arrive4");
    step(1, 1, 0, 1, 16'h5A, I, 0, 0, "pin_ok4");
    step(1, 1, 1, 0, 16'h00, B, 0, 0, "tailgate");
    step(1, 0, 0, 1, 16'h33, B, 1, 0, "lock_wrong1");
    step(1, 0, 0, 1, 16'h44, B, 1, 0, "lock_wrong2");
    step(1, 0, 0, 1, 16'h5A, E, 0, 0, "lock_ok4");

    // 5: unauthorised entry, abandon after wrong PIN, ingreso beats a good PIN
    step(1, 0, 1, 0, 16'h00, B, 0, 0, "esp_intrude");
    step(1, 0, 0, 1, 16'h5A, E, 0, 0, "intrude_ok");
    step(1, 1, 0, 0, 16'h00, V, 0, 0, "arrive5");
    step(1, 1, 0, 1, 16'h01, V, 1, 1, "wrong5");
    step(1, 0, 0, 0, 16'h00, E, 0, 0, "leave");
    step(1, 1, 0, 0, 16'h00, V, 0, 0, "arrive5b");
    step(1, 1, 1, 1, 16'h5A, B, 0, 0, "veh_ingr_prio");
    step(1, 0, 0, 1, 16'h5A, E, 0, 0, "prio_ok");

    // 6a: asynchronous reset while the gate is open
    step(1, 1, 0, 0, 16'h00, V, 0, 0, "arrive6");
    step(1, 1, 0, 1, 16'h5A, I, 0, 0, "pin_ok6");
    #2 rst = 1'b1;
    #1 check_eq("async_rst", 32'(observed(1)), 32'({E, 6'b0}));
    #1 rst = 1'b0;
    step(1, 0, 0, 0, 16'h00, E, 0, 0, "after_rst");

    // 6b: 16-bit PIN, five attempts; near-miss PINs must not match
    step(2, 1, 0, 0, 16'h0000, V, 0, 0, "w_arrive");
    step(2, 1, 0, 1, 16'h00C3, V, 1, 1, "w_wrong1");
    step(2, 1, 0, 1, 16'hA5C2, V, 1, 2, "w_wrong2");
    step(2, 1, 0, 1, 16'h25C3, V, 1, 3, "w_wrong3");
    step(2, 1, 0, 1, 16'h005A, V, 1, 4, "w_wrong4");
    step(2, 1, 0, 1, 16'hFFFF, B, 1, 5, "w_wrong5_lock");
    step(2, 0, 0, 1, 16'h1234, B, 1, 5, "w_lock_sat");
    step(2, 0, 0, 1, 16'hA5C3, E, 0, 0, "w_release");

    if (sb.size() != 0) check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/access_control_param.md
Name: access_control_param

Overview:
Parametrised next-generation parking access controller: arrival detection, PIN check with configurable width and attempt limit, gate-open timeout, tailgating detection and lockout with PIN-only recovery. It sits between the vehicle sensors / keypad front end and the gate actuator and alarm drivers. Adds an entry timeout, a tailgate lock, a visible failed-attempt count and a registered state output.

Parameters:
ANCHO_CLAVE, 8, PIN width in bits.
CLAVE_CORRECTA, 8'h5A, valid PIN; compared over ANCHO_CLAVE bits.
MAX_INTENTOS, 3, failed attempts that trigger lockout; legal range 1..(2**ANCHO_INTENTOS)-1.
ANCHO_INTENTOS, 2, width of the attempt counter.
TIEMPO_LIMITE, 200, clock cycles the gate stays open with no entry seen.
ANCHO_TIEMPO, 8, width of the timeout counter; must hold TIEMPO_LIMITE.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high; returns all state to reset values immediately.
sensor_llegada_vehiculo  input  1  level; vehicle present at the keypad.
sensor_ingreso_vehiculo  input  1  level; vehicle passing the gate.
clave_ingresada  input  ANCHO_CLAVE  PIN; sampled only when clave_valida=1.
clave_valida  input  1  one-cycle strobe: PIN entry complete.
senal_compuerta  output  1  1 = open gate.
senal_alarma_pin  output  1  wrong-PIN alarm.
senal_alarma_bloqueo  output  1  lockout / tailgate alarm.
intentos_fallidos  output  ANCHO_INTENTOS  current failed-attempt count.
estado  output  4  one-hot state: bit0 ESPERA, bit1 VEHICULO, bit2 INGRESANDO, bit3 BLOQUEO.

Behaviour:
- Reset (asynchronous): estado=ESPERA (4'b0001); intentos=0; timer=0; vio_ingreso=0; alarma_pin flag=0. All outputs 0 except estado.
- All state is registered. Outputs are a Moore decode of the registers. Any decision made on clock edge N is visible on the outputs right after edge N; there is no extra latency.
- senal_compuerta = (estado==INGRESANDO).
- senal_alarma_bloqueo = (estado==BLOQUEO).
- senal_alarma_pin = flag register.
- ESPERA:
  - sensor_ingreso=1 goes to BLOQUEO (unauthorised entry). This has priority.
  - Else sensor_llegada=1 goes to VEHICULO.
  - clave_valida is ignored.
- VEHICULO (priority order, highest first):
  - (1) sensor_ingreso=1 goes to BLOQUEO.
  - (2) clave_valida with a matching PIN goes to INGRESANDO, clears intentos and the pin flag, and loads timer=0, vio_ingreso=0.
  - (3) clave_valida with a wrong PIN sets the pin flag and increments intentos. If the new count equals MAX_INTENTOS, go to BLOQUEO; otherwise stay.
  - (4) sensor_llegada=0 goes to ESPERA and clears intentos and the pin flag.
- INGRESANDO:
  - Both sensors at 1 in the same cycle goes to BLOQUEO (tailgating). This has priority.
  - sensor_ingreso=1 sets vio_ingreso.
  - When vio_ingreso=1 and sensor_ingreso=0, go to ESPERA (vehicle has passed).
  - While vio_ingreso=0, the timer increments each cycle. When timer==TIEMPO_LIMITE-1, go to ESPERA (gate closes).
  - Once vio_ingreso=1 the timer holds.
  - clave_valida is ignored.
- BLOQUEO:
  - Sensors are ignored.
  - A wrong PIN sets the pin flag; intentos saturates at MAX_INTENTOS and does not wrap.
  - A correct PIN goes to ESPERA, clears intentos and the pin flag, and deasserts senal_alarma_bloqueo.
- Width rules:
  - The PIN compare is an exact ANCHO_CLAVE-bit equality.
  - The intentos increment never wraps; it is bounded by MAX_INTENTOS.
  - The timer never exceeds TIEMPO_LIMITE-1.
- Reset asserted mid-operation (including during an open gate or BLOQUEO) returns to ESPERA immediately, with senal_compuerta=0 asynchronously.
- A clave_valida strobe held high for more than one cycle is evaluated every cycle it is high; the strobe is not edge-detected.

Test Plan:
1. Reset, then sensor_llegada=1, then clave_valida with 8'h5A: estado 0001->0010->0100, senal_compuerta=1 on the strobe edge. Then ingreso 1 for 3 cycles, then 0: compuerta=0, estado=0001 the edge ingreso falls.
2. In VEHICULO, two wrong PINs (8'h00, 8'h11): intentos=1 then 2, senal_alarma_pin=1, still VEHICULO. Third wrong PIN: intentos=3, estado=1000, senal_alarma_bloqueo=1. Then 8'h5A: estado=0001, all alarms 0, intentos=0.
3. Gate open with no ingreso for TIEMPO_LIMITE=200 cycles: compuerta deasserts exactly 200 edges after the PIN edge; estado=0001.
4. In INGRESANDO, drive both sensors=1 in one cycle: estado=1000, compuerta=0, bloqueo=1 on that edge. Wrong PINs in BLOQUEO keep intentos=0 and set alarma_pin. Then 8'h5A: back to ESPERA.
5. ESPERA with sensor_ingreso=1: BLOQUEO. Separately, VEHICULO with one wrong PIN then sensor_llegada=0: ESPERA with intentos=0 and alarma_pin=0.
6. Assert reset asynchronously mid-clock while in INGRESANDO: compuerta falls before the next edge and estado=0001. Repeat scenario 2 with ANCHO_CLAVE=16, MAX_INTENTOS=5, ANCHO_INTENTOS=3: lockout occurs on the 5th failure.
